// File: rtl/frame_sync.sv
// Frame synchronizer: hunts for the attached sync marker (true or inverted),
// then emits payload bytes and checks each following marker with error tolerance.
module frame_sync #(
   parameter logic [31:0] ASM        = 32'h1ACFFC1D,
   parameter int          DATA_BYTES = 1020,
   parameter int          ASM_TOL    = 3,
   parameter int          MISS_LIMIT = 4
) (
   input  logic        clk_100mhz,
   input  logic        sys_rst,
   input  logic        bit_in,
   input  logic        valid_in,
   output logic [7:0]  byte_out,
   output logic        valid_out,
   output logic        sof,
   output logic        locked,
   output logic        inverted,
   output logic [15:0] frame_count
);
   localparam int FRAME_BITS = DATA_BYTES * 8;
   localparam int BCW        = $clog2(FRAME_BITS);
   localparam int MW         = $clog2(MISS_LIMIT + 1);
   localparam logic [BCW-1:0] BC_LAST  = BCW'(FRAME_BITS - 1);
   localparam logic [BCW-1:0] BC_SOF   = BCW'(7);
   localparam logic [MW-1:0]  MISS_MAX = MW'(MISS_LIMIT);

   typedef enum logic [1:0] {SEARCH, PAYLOAD, ASM_CHK} state_t;

   state_t           r_state, w_state_nxt;
   // Only the 31 oldest bits need storing; the newest comes straight from bit_in.
   logic [30:0]      r_sr;
   logic [BCW-1:0]   r_bc, w_bc_nxt;
   logic [4:0]       r_acnt, w_acnt_nxt;
   logic [MW-1:0]    r_miss, w_miss_nxt, w_miss_inc;
   logic             r_inv, w_inv_nxt;
   logic [15:0]      r_fc, w_fc_nxt;
   logic [7:0]       r_byte, w_byte_nxt;
   logic             r_vout, w_vout_nxt;
   logic             r_sof, w_sof_nxt;
   logic             r_locked;
   logic [31:0]      w_win, w_diff;
   logic [5:0]       w_err;

   assign w_win      = {r_sr, bit_in};
   assign w_diff     = w_win ^ ASM ^ {32{r_inv}};
   assign w_miss_inc = r_miss + MW'(1);

   always_comb begin
      w_err = '0;
      for (int i = 0; i < 32; i++) w_err = w_err + 6'(w_diff[i]);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bc_nxt    = r_bc;
      w_acnt_nxt  = r_acnt;
      w_miss_nxt  = r_miss;
      w_inv_nxt   = r_inv;
      w_fc_nxt    = r_fc;
      w_byte_nxt  = r_byte;
      w_vout_nxt  = 1'b0;
      w_sof_nxt   = 1'b0;
      if (valid_in) begin
         case (r_state)
            SEARCH: begin
               if (w_win == ASM || w_win == ~ASM) begin
                  w_inv_nxt   = (w_win != ASM);
                  w_state_nxt = PAYLOAD;
                  w_fc_nxt    = r_fc + 16'd1;
                  w_bc_nxt    = '0;
               end
            end
            PAYLOAD: begin
               if (r_bc[2:0] == 3'd7) begin
                  w_byte_nxt = w_win[7:0] ^ {8{r_inv}};
                  w_vout_nxt = 1'b1;
                  w_sof_nxt  = (r_bc == BC_SOF);
               end
               if (r_bc == BC_LAST) begin
                  w_bc_nxt    = '0;
                  w_acnt_nxt  = '0;
                  w_state_nxt = ASM_CHK;
               end else begin
                  w_bc_nxt = r_bc + BCW'(1);
               end
            end
            ASM_CHK: begin
               if (r_acnt == 5'd31) begin
                  w_acnt_nxt = '0;
                  if (w_err <= 6'(ASM_TOL)) begin
                     w_miss_nxt  = '0;
                     w_fc_nxt    = r_fc + 16'd1;
                     w_state_nxt = PAYLOAD;
                  end else if (w_miss_inc == MISS_MAX) begin
                     w_miss_nxt  = '0;
                     w_state_nxt = SEARCH;
                  end else begin
                     // flywheel: keep framing through a bad marker
                     w_miss_nxt  = w_miss_inc;
                     w_state_nxt = PAYLOAD;
                  end
               end else begin
                  w_acnt_nxt = r_acnt + 5'd1;
               end
            end
            default: w_state_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (sys_rst) begin
         r_state  <= SEARCH;
         r_sr     <= '0;
         r_bc     <= '0;
         r_acnt   <= '0;
         r_miss   <= '0;
         r_inv    <= 1'b0;
         r_fc     <= '0;
         r_byte   <= '0;
         r_vout   <= 1'b0;
         r_sof    <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         if (valid_in) r_sr <= w_win[30:0];
         r_state  <= w_state_nxt;
         r_bc     <= w_bc_nxt;
         r_acnt   <= w_acnt_nxt;
         r_miss   <= w_miss_nxt;
         r_inv    <= w_inv_nxt;
         r_fc     <= w_fc_nxt;
         r_byte   <= w_byte_nxt;
         r_vout   <= w_vout_nxt;
         r_sof    <= w_sof_nxt;
         r_locked <= (w_state_nxt != SEARCH);
      end
   end

   assign byte_out    = r_byte;
   assign valid_out   = r_vout;
   assign sof         = r_sof;
   assign locked      = r_locked;
   assign inverted    = r_inv;
   assign frame_count = r_fc;
endmodule

// File: tb/tb_frame_sync.sv
// Bench for frame_sync: frames are built from known bytes and marker error counts;
// expected bytes/status come from a frame-level model of the locking rules.
module tb_frame_sync;
   localparam logic [31:0] ASM = 32'h1ACFFC1D;
   localparam int DB = 4;
   localparam int TOL = 3;
   localparam int MLIM = 4;

   logic clk_100mhz = 1'b0, sys_rst = 1'b1, bit_in = 1'b0, valid_in = 1'b0;
   logic [7:0]  byte_out;
   logic        valid_out, sof, locked, inverted;
   logic [15:0] frame_count;

   frame_sync #(.ASM(ASM), .DATA_BYTES(DB), .ASM_TOL(TOL), .MISS_LIMIT(MLIM)) dut (
      .clk_100mhz(clk_100mhz), .sys_rst(sys_rst), .bit_in(bit_in), .valid_in(valid_in),
      .byte_out(byte_out), .valid_out(valid_out), .sof(sof), .locked(locked),
      .inverted(inverted), .frame_count(frame_count));

   always #5 clk_100mhz = ~clk_100mhz;

   int n_err = 0, n_chk = 0, gap = 0, lat_bad = 0;
   logic last_vin = 1'b0;
   logic [8:0] got_q[$], exp_q[$];
   // frame-level model state
   logic m_locked = 1'b0, m_inv = 1'b0;
   logic [15:0] m_fc = '0;
   int m_miss = 0;

   always @(posedge clk_100mhz) last_vin <= valid_in;
   always @(negedge clk_100mhz)
      if (valid_out) begin
         got_q.push_back({sof, byte_out});
         if (!last_vin) lat_bad++;
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bit_in = b; valid_in = 1'b1;
      @(posedge clk_100mhz); #1;
      valid_in = 1'b0; bit_in = 1'($urandom_range(1, 0));
      repeat (gap) begin @(posedge clk_100mhz); #1; end
   endtask

   task automatic send_noise(input int n);
      for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)));
   endtask

   task automatic send_marker(input int errs, input logic txinv);
      logic [31:0] mask, bits;
      mask = '0;
      while ($countones(mask) < errs) mask[$urandom_range(31, 0)] = 1'b1;
      bits = ASM ^ {32{txinv}} ^ mask;
      for (int i = 31; i >= 0; i--) send_bit(bits[i]);
      if (!m_locked) begin
         if (errs == 0) begin m_locked = 1'b1; m_inv = txinv; m_fc++; m_miss = 0; end
      end else if (errs <= TOL) begin
         m_fc++; m_miss = 0;
      end else begin
         m_miss++;
         if (m_miss == MLIM) begin m_locked = 1'b0; m_miss = 0; end
      end
   endtask

   task automatic send_payload(input logic [31:0] data, input logic txinv, input int first, input int last);
      logic [7:0] b;
      for (int k = first; k <= last; k++) begin
         b = data[31-8*k -: 8];
         for (int i = 7; i >= 0; i--) send_bit(b[i] ^ txinv);
         if (m_locked) exp_q.push_back({1'(k == 0), b});
      end
   endtask

   task automatic check_frames(input string tag);
      repeat (2) begin @(posedge clk_100mhz); #1; end
      chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      chk({tag, "_fc"}, 32'(frame_count), 32'(m_fc));
      chk({tag, "_locked"}, 32'(locked), 32'(m_locked));
      chk({tag, "_inv"}, 32'(inverted), 32'(m_inv));
      got_q.delete(); exp_q.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_byte"}, 32'(byte_out), 32'h0);
      chk({tag, "_vout"}, 32'(valid_out), 32'h0);
      chk({tag, "_sof"}, 32'(sof), 32'h0);
      chk({tag, "_locked"}, 32'(locked), 32'h0);
      chk({tag, "_inv"}, 32'(inverted), 32'h0);
      chk({tag, "_fc"}, 32'(frame_count), 32'h0);
   endtask

   // valid_in held high during reset to exercise reset priority
   task automatic do_reset(input string tag);
      valid_in = 1'b1; bit_in = 1'b1; sys_rst = 1'b1;
      @(posedge clk_100mhz); #1;
      sys_rst = 1'b0; valid_in = 1'b0;
      m_locked = 1'b0; m_inv = 1'b0; m_fc = '0; m_miss = 0;
      check_zero(tag);
   endtask

   initial begin
      repeat (3) @(posedge clk_100mhz);
      #1 sys_rst = 1'b0;
      check_zero("por");

      // acquisition on a clean marker
      send_noise(20);
      send_marker(0, 1'b0);
      chk("acq_locked_after_marker", 32'(locked), 32'h1);
      chk("acq_fc_after_marker", 32'(frame_count), 32'h1);
      send_payload(32'hA53CFF00, 1'b0, 0, DB-1);
      check_frames("acq");

      // tolerance: 3 errors accepted, 4 errors is a flywheel miss
      send_marker(3, 1'b0);
      chk("tol3_fc", 32'(frame_count), 32'(m_fc));
      send_payload($urandom, 1'b0, 0, DB-1);
      send_marker(4, 1'b0);
      chk("tol4_fc", 32'(frame_count), 32'(m_fc));
      send_payload($urandom, 1'b0, 0, DB-1);
      check_frames("tol");

      // three more bad markers complete four consecutive misses
      for (int f = 0; f < 3; f++) begin
         send_marker(4 + f, 1'b0);
         chk($sformatf("loss_locked%0d", f), 32'(locked), 32'(m_locked));
         send_payload($urandom, 1'b0, 0, DB-1);
      end
      check_frames("loss");
      send_noise(200);
      check_frames("noise");
      send_marker(0, 1'b0);
      send_payload($urandom, 1'b0, 0, DB-1);
      check_frames("reacq");

      // inverted stream
      do_reset("rst_inv");
      send_noise(17);
      send_marker(0, 1'b1);
      send_payload(32'hA53CFF00, 1'b1, 0, DB-1);
      check_frames("inv");
      send_marker(2, 1'b1);
      send_payload($urandom, 1'b1, 0, DB-1);
      check_frames("inv2");

      // sparse valid_in: same bytes, latency still one cycle
      do_reset("rst_gap");
      gap = 2;
      send_noise(9);
      send_marker(0, 1'b0);
      send_payload(32'hA53CFF00, 1'b0, 0, DB-1);
      check_frames("gap");
      chk("gap_latency", 32'(lat_bad), 32'h0);
      gap = 0;

      // reset mid-frame aborts output until the next marker
      do_reset("rst_pre");
      send_noise(5);
      send_marker(0, 1'b0);
      send_payload(32'hA53CFF00, 1'b0, 0, 1);
      do_reset("rst_mid");
      send_payload(32'hA53CFF00, 1'b0, 2, DB-1);
      send_marker(0, 1'b0);
      send_payload($urandom, 1'b0, 0, DB-1);
      check_frames("rst_resync");
      chk("final_latency", 32'(lat_bad), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/frame_sync.md
FRAME_SYNC -- requirements
Module: frame_sync

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter ASM, 32'h1ACFFC1D, SHALL be the attached sync marker, transmitted MSB first.
REQ-003 Parameter DATA_BYTES, 1020, SHALL be the payload bytes between consecutive markers.
REQ-004 Parameter ASM_TOL, 3, SHALL be the max marker bit errors tolerated while locked.
REQ-005 Parameter MISS_LIMIT, 4, SHALL be the consecutive marker misses that drop lock.
REQ-006 Port list SHALL be:
  clk_100mhz  in   1   system clock, all logic on rising edge
  sys_rst     in   1   synchronous active-high reset
  bit_in      in   1   decoded bit from the Viterbi stage (vit_desc)
  valid_in    in   1   bit_in valid this cycle; single-cycle pulse per bit, back-to-back allowed
  byte_out    out  8   payload byte, first-received bit in bit 7, inversion corrected
  valid_out   out  1   byte_out valid, one-cycle pulse
  sof         out  1   qualifies valid_out: first payload byte of a frame
  locked      out  1   1 in PAYLOAD or ASM_CHK
  inverted    out  1   1 when the stream matched ~ASM (BPSK/QPSK phase ambiguity)
  frame_count out  16  markers accepted (search hits plus locked hits), wraps 16'hFFFF->0

Function
REQ-007 A 32-bit shift register SR SHALL shift bit_in in at the LSB on every valid_in, in every state.
REQ-008 W SHALL denote the post-shift window {SR[30:0], bit_in}; all marker compares use W.
REQ-009 No state, counter, or output SHALL change on cycles with valid_in=0, except that valid_out/sof deassert.
REQ-010 States SHALL be SEARCH, PAYLOAD, and ASM_CHK; the reset state SHALL be SEARCH.
REQ-011 In SEARCH, when W==ASM the block SHALL set inverted=0, enter PAYLOAD, and increment frame_count.
REQ-012 In SEARCH, when W==~ASM the block SHALL set inverted=1, enter PAYLOAD, and increment frame_count.
REQ-013 In SEARCH, only an exact match SHALL be accepted; inexact windows SHALL be ignored.
REQ-014 In PAYLOAD, bit counter BC SHALL count 0..DATA_BYTES*8-1.
REQ-015 In PAYLOAD, when BC[2:0]==7 the block SHALL emit byte_out = {last 8 bits} XOR {8{inverted}}.
REQ-016 The emitted byte SHALL be registered with valid_out=1 in the cycle after that valid_in (latency 1).
REQ-017 sof SHALL be 1 with the byte for which BC==7.
REQ-018 The valid_in carrying BC==DATA_BYTES*8-1 SHALL emit the last byte, clear BC, and enter ASM_CHK.
REQ-019 In ASM_CHK, 32 bits SHALL be counted; on the 32nd, E = popcount(W XOR ASM XOR {32{inverted}}).
REQ-020 If E<=ASM_TOL the block SHALL clear the miss counter, increment frame_count, and enter PAYLOAD.
REQ-021 If E>ASM_TOL the miss counter SHALL increment.
REQ-022 On a miss, if the miss counter then equals MISS_LIMIT the block SHALL enter SEARCH, clear the miss counter, and leave inverted unchanged.
REQ-023 On a miss below MISS_LIMIT (flywheel) the block SHALL enter PAYLOAD and emit the frame normally, without incrementing frame_count.
REQ-024 No bytes SHALL be emitted in SEARCH or ASM_CHK.
REQ-025 A partial byte SHALL never be emitted.
REQ-026 SR history SHALL be retained on loss of lock, so a marker already in W is acquired on the next valid_in's window.
REQ-027 locked SHALL be a registered output reflecting the current state.

Reset
REQ-028 While sys_rst=1, sys_rst SHALL take priority over valid_in.
REQ-029 Reset SHALL clear SR, BC, and the miss counter and set state=SEARCH.
REQ-030 Reset SHALL set byte_out=0, valid_out=0, sof=0, locked=0, inverted=0, and frame_count=0.
REQ-031 Reset asserted mid-frame SHALL abort with no further valid_out until reacquisition.

Verification (DATA_BYTES=4 unless noted)
REQ-032 Acquire: bits of 32'h1ACFFC1D, then 8'hA5,8'h3C,8'hFF,8'h00 -> 4 valid_out pulses A5(sof=1),3C,FF,00; locked=1 after the marker; frame_count=1.
REQ-033 Inversion: complement the whole stream of REQ-032 -> inverted=1; same four bytes out.
REQ-034 Tolerance: second marker with 3 flipped bits -> accepted, frame_count=2; with 4 flipped bits -> miss, frame still emitted, frame_count stays 1.
REQ-035 Loss of lock: 4 consecutive corrupted markers -> locked=0 after the 4th; noise without a marker -> no valid_out; a clean marker -> reacquired.
REQ-036 Gaps: valid_in every 3rd cycle versus every cycle -> identical byte sequence; each valid_out exactly 1 cycle after the byte's 8th valid_in.
REQ-037 Reset: sys_rst pulsed after 2 payload bytes -> all outputs 0 next cycle; no 3rd byte; resync on the next marker.
